mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage access controller for the 16-bit pipeline: the initiator side of the data-memory port. It accepts load/store/ALU instructions from the EX/MEM pipeline register. It drives the data memory's `read_mem`/`write_mem`/`rw_address`/`write_data` signals with stable, registered values for a programmable number of cycles, and samples `read_data`. It retires each instruction into the MEM/WB register and stalls upstream while an access is in flight.

## Interface
- `DATA_W`, 16: data width; must match the data memory word.
- `ADDR_W`, 16: address width; the data memory decodes only `rw_address[3:0]`.
- `WAIT_CYCLES`, 1: cycles a request is held on the memory port before the result is sampled. Legal range 1..15.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `ex_valid` in 1: an instruction is present on the `ex_*` inputs.
- `ex_mem_read` in 1: the instruction is a load.
- `ex_mem_write` in 1: the instruction is a store.
- `ex_addr` in ADDR_W: effective address.
- `ex_store_data` in DATA_W: store data.
- `ex_alu_result` in DATA_W: result for non-memory instructions.
- `ex_rd` in 3: destination register index.
- `ex_reg_write` in 1: the instruction writes the register file.
- `stall` out 1: hold the EX/MEM register; combinational.
- `read_mem` out 1: memory read strobe.
- `write_mem` out 1: memory write strobe.
- `rw_address` out ADDR_W: memory address.
- `write_data` out DATA_W: memory write data.
- `read_data` in DATA_W: memory read data; combinational from `rw_address`.
- `wb_valid` out 1: one-cycle pulse per retired instruction.
- `wb_reg_write` out 1: register-file write enable for the retired instruction.
- `wb_rd` out 3: destination index of the retired instruction.
- `wb_data` out DATA_W: load data or ALU result.

## Operation
- **FSM states:** IDLE, ACCESS. Wait counter `cnt` is 4 bits wide.
- **IDLE with a memory op** (`ex_valid & (ex_mem_read | ex_mem_write)`):
  - Latch address, store data, rd, reg_write, and op type.
  - Load `rw_address`/`write_data` registers.
  - Set `cnt = WAIT_CYCLES-1` and go to ACCESS.
- **IDLE with a non-memory op** (`ex_valid`, neither flag set):
  - Next edge: `wb_valid=1`, `wb_data=ex_alu_result`, `wb_rd=ex_rd`, `wb_reg_write=ex_reg_write`.
  - Stay in IDLE; no memory strobe.
- **ACCESS:**
  - `read_mem` (load) or `write_mem` (store) is high, registered.
  - `rw_address`/`write_data` are constant for the whole state.
  - `cnt` decrements each cycle.
  - When `cnt==0`: next edge captures `read_data` (load) or the latched ALU value (store) into `wb_data`, pulses `wb_valid`, and returns to IDLE with both strobes low.
- **Store retire:** `wb_valid=1`, `wb_reg_write=0`, `wb_data` = latched `ex_alu_result`.
- **Both flags set:** treated as a store (`write_mem` only; `read_mem` stays low).
- **Stall:** `stall = (IDLE & ex_valid & (ex_mem_read|ex_mem_write)) | (ACCESS & cnt!=0)`.
- **Inputs in ACCESS:** `ex_*` inputs are ignored while in ACCESS.
- **Address width:** full ADDR_W address is driven unmodified; no alignment or range check.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, `cnt=0`.
- **Memory op cost:** WAIT_CYCLES+1 cycles, with `stall` high for WAIT_CYCLES cycles. `wb_valid` rises WAIT_CYCLES+1 edges after acceptance.
- **Non-memory op:** 1-cycle latency, zero stall; back-to-back issue every cycle.
- **Strobes:** `read_mem`/`write_mem` go high the edge after acceptance and stay high for exactly WAIT_CYCLES cycles. They are never both high.
- **Memory-port stability:** `rw_address`/`write_data` change only on the acceptance edge and hold their last value in IDLE, so memory sees no address change while a strobe is high.
- **Back-to-back memory ops:** the next op is accepted in the IDLE cycle immediately after retire. No idle bubble beyond the acceptance cycle.
- **`wb_valid`:** deasserts the cycle after each pulse unless another instruction retires.
- **Reset mid-ACCESS:** strobes drop on the reset edge, no `wb_valid`, the instruction is lost. A store may already have been written by memory.

## Test plan
- **Reset:** hold `rst_n=0` 2 cycles with `ex_valid=1` load -> all outputs 0, no strobe, `stall` low after release only until re-accept.
- **Load, WAIT_CYCLES=1:** memory word 3 = 0xBEEF; issue load `ex_addr=0x0003`, `ex_rd=5` -> `read_mem` high 1 cycle, `stall` high 1 cycle, `wb_valid` with `wb_data=0xBEEF`, `wb_rd=5`, `wb_reg_write=1` 2 edges after accept.
- **Store then load:** store 0x1234 to address 0x0007, then load 0x0007 -> `write_mem` high with `write_data=0x1234`, store retires `wb_reg_write=0`, load returns 0x1234.
- **WAIT_CYCLES=3:** single load -> `read_mem` high exactly 3 cycles, `stall` high 3 cycles, address constant throughout, result on 4th edge.
- **ALU stream with a mid load:** 3 ALU ops (0x0001..0x0003), a load, 2 more ALU ops -> `wb_valid` every cycle except during the load's stall cycles, in-order `wb_data`.
- **Reset mid-ACCESS:** assert `rst_n=0` during ACCESS (WAIT_CYCLES=3) -> strobes low next edge, no `wb_valid`, FSM in IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Memory-stage access controller for the 16-bit pipeline. It sits between the
// EX/MEM pipeline register and the data memory and acts as the initiator on
// the data-memory port. Loads and stores hold registered strobes, address and
// write data on the port for WAIT_CYCLES cycles, then retire into MEM/WB.
// Non-memory instructions retire on the next edge with no stall.
//
// Ports
//   clk, rst_n          : clock and synchronous active-low reset
//   ex_valid            : an instruction is present on the ex_* inputs
//   ex_mem_read/write   : load / store flags (both set counts as a store)
//   ex_addr             : effective address
//   ex_store_data       : store data
//   ex_alu_result       : result of non-memory instructions, also retired for stores
//   ex_rd, ex_reg_write : destination register index and write enable
//   stall               : hold the EX/MEM register (combinational)
//   read_mem, write_mem : registered memory strobes
//   rw_address          : registered memory address
//   write_data          : registered memory write data
//   read_data           : memory read data, combinational from rw_address
//   wb_valid            : one-cycle pulse per retired instruction
//   wb_reg_write, wb_rd : register-file write enable and index for MEM/WB
//   wb_data             : load data or ALU result for MEM/WB
module mem_access_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [2:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic              stall,
    output logic              read_mem,
    output logic              write_mem,
    output logic [ADDR_W-1:0] rw_address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [2:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    // The counter starts at WAIT_CYCLES-1 so that the strobe, which rises on
    // the acceptance edge, stays up for exactly WAIT_CYCLES cycles.
    localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        rd_q, rd_d;
    logic              regWrite_q, regWrite_d;
    logic [DATA_W-1:0] aluResult_q, aluResult_d;
    logic              readMem_q, readMem_d;
    logic              writeMem_q, writeMem_d;
    logic [ADDR_W-1:0] rwAddress_q, rwAddress_d;
    logic [DATA_W-1:0] writeData_q, writeData_d;
    logic              wbValid_q, wbValid_d;
    logic              wbRegWrite_q, wbRegWrite_d;
    logic [2:0]        wbRd_q, wbRd_d;
    logic [DATA_W-1:0] wbData_q, wbData_d;
    logic              memOp;

    assign memOp = ex_valid & (ex_mem_read | ex_mem_write);

    // Stall holds a memory op in EX/MEM from its acceptance cycle until the
    // last ACCESS cycle, so the instruction behind it lines up with the
    // IDLE cycle right after retire. Forced low while reset is asserted so
    // every output reads zero during reset.
    assign stall = rst_n & (((state_q == IDLE) & memOp) |
                            ((state_q == ACCESS) & (cnt_q != 4'd0)));

    assign read_mem     = readMem_q;
    assign write_mem    = writeMem_q;
    assign rw_address   = rwAddress_q;
    assign write_data   = writeData_q;
    assign wb_valid     = wbValid_q;
    assign wb_reg_write = wbRegWrite_q;
    assign wb_rd        = wbRd_q;
    assign wb_data      = wbData_q;

    // State register. All updates, including reset, happen on the rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_q         <= '0;
            regWrite_q   <= 1'b0;
            aluResult_q  <= '0;
            readMem_q    <= 1'b0;
            writeMem_q   <= 1'b0;
            rwAddress_q  <= '0;
            writeData_q  <= '0;
            wbValid_q    <= 1'b0;
            wbRegWrite_q <= 1'b0;
            wbRd_q       <= '0;
            wbData_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            regWrite_q   <= regWrite_d;
            aluResult_q  <= aluResult_d;
            readMem_q    <= readMem_d;
            writeMem_q   <= writeMem_d;
            rwAddress_q  <= rwAddress_d;
            writeData_q  <= writeData_d;
            wbValid_q    <= wbValid_d;
            wbRegWrite_q <= wbRegWrite_d;
            wbRd_q       <= wbRd_d;
            wbData_q     <= wbData_d;
        end
    end

    // Next-state logic. The memory port registers (address, write data) only
    // change on acceptance, so the memory never sees the address move while
    // a strobe is high. The wb_* payload holds its last value; only wb_valid
    // is a pulse. A store that also has the read flag set is a plain store.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        regWrite_d   = regWrite_q;
        aluResult_d  = aluResult_q;
        readMem_d    = 1'b0;
        writeMem_d   = 1'b0;
        rwAddress_d  = rwAddress_q;
        writeData_d  = writeData_q;
        wbValid_d    = 1'b0;
        wbRegWrite_d = wbRegWrite_q;
        wbRd_d       = wbRd_q;
        wbData_d     = wbData_q;

        unique case (state_q)
            IDLE: begin
                if (memOp) begin
                    rd_d        = ex_rd;
                    regWrite_d  = ex_reg_write;
                    aluResult_d = ex_alu_result;
                    rwAddress_d = ex_addr;
                    writeData_d = ex_store_data;
                    readMem_d   = ~ex_mem_write;
                    writeMem_d  = ex_mem_write;
                    cnt_d       = CntInit;
                    state_d     = ACCESS;
                end else if (ex_valid) begin
                    wbValid_d    = 1'b1;
                    wbData_d     = ex_alu_result;
                    wbRd_d       = ex_rd;
                    wbRegWrite_d = ex_reg_write;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d      = cnt_q - 4'd1;
                    readMem_d  = readMem_q;
                    writeMem_d = writeMem_q;
                end else begin
                    wbValid_d    = 1'b1;
                    wbRd_d       = rd_q;
                    wbRegWrite_d = regWrite_q & ~writeMem_q;
                    wbData_d     = writeMem_q ? aluResult_q : read_data;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. Two instances share the ex_* stimulus:
// dut1 runs with WAIT_CYCLES=1, dut3 with WAIT_CYCLES=3, each with its own
// reset and its own 16-word data memory model. Every scenario resets both
// instances first, so stimulus aimed at one leaves the other in a known state.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rstN1, rstN3;
    logic        loadMem;
    logic        exValid, exMemRead, exMemWrite, exRegWrite;
    logic [15:0] exAddr, exStoreData, exAluResult;
    logic [2:0]  exRd;

    logic        stall1, readMem1, writeMem1, wbValid1, wbRegWrite1;
    logic [15:0] rwAddress1, writeData1, readData1, wbData1;
    logic [2:0]  wbRd1;
    logic        stall3, readMem3, writeMem3, wbValid3, wbRegWrite3;
    logic [15:0] rwAddress3, writeData3, readData3, wbData3;
    logic [2:0]  wbRd3;

    logic [15:0] mem1 [16];
    logic [15:0] mem3 [16];

    int checks;
    int errors;

    // ALU stream: six instructions, the fourth is a load of word 3 (0xBEEF).
    // Per-cycle expectations are hand derived for WAIT_CYCLES=1: the load
    // stalls only in its acceptance cycle and retires one cycle later.
    localparam logic [5:0]  LOAD_TAB  = 6'b001000;
    localparam logic [15:0] ALU_TAB [6] = '{16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0004, 16'h0005};
    localparam logic [6:0]  EXP_STALL = 7'b0001000;
    localparam logic [6:0]  EXP_WBV   = 7'b1110111;
    localparam logic [15:0] EXP_WBD [7] = '{16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'hBEEF, 16'h0004, 16'h0005};

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rstN1), .ex_valid(exValid), .ex_mem_read(exMemRead),
        .ex_mem_write(exMemWrite), .ex_addr(exAddr), .ex_store_data(exStoreData),
        .ex_alu_result(exAluResult), .ex_rd(exRd), .ex_reg_write(exRegWrite),
        .stall(stall1), .read_mem(readMem1), .write_mem(writeMem1),
        .rw_address(rwAddress1), .write_data(writeData1), .read_data(readData1),
        .wb_valid(wbValid1), .wb_reg_write(wbRegWrite1), .wb_rd(wbRd1), .wb_data(wbData1)
    );

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rstN3), .ex_valid(exValid), .ex_mem_read(exMemRead),
        .ex_mem_write(exMemWrite), .ex_addr(exAddr), .ex_store_data(exStoreData),
        .ex_alu_result(exAluResult), .ex_rd(exRd), .ex_reg_write(exRegWrite),
        .stall(stall3), .read_mem(readMem3), .write_mem(writeMem3),
        .rw_address(rwAddress3), .write_data(writeData3), .read_data(readData3),
        .wb_valid(wbValid3), .wb_reg_write(wbRegWrite3), .wb_rd(wbRd3), .wb_data(wbData3)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memories: combinational read decoding rw_address[3:0], write on the
    // clock edge while write_mem is high. loadMem preloads the test words.
    assign readData1 = mem1[rwAddress1[3:0]];
    assign readData3 = mem3[rwAddress3[3:0]];

    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= 16'h0000;
                mem3[i] <= 16'h0000;
            end
            mem1[3] <= 16'hBEEF;
            mem3[4] <= 16'hCAFE;
        end else begin
            if (writeMem1) mem1[rwAddress1[3:0]] <= writeData1;
            if (writeMem3) mem3[rwAddress3[3:0]] <= writeData3;
        end
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        exValid     = 1'b0;
        exMemRead   = 1'b0;
        exMemWrite  = 1'b0;
        exAddr      = 16'h0000;
        exStoreData = 16'h0000;
        exAluResult = 16'h0000;
        exRd        = 3'd0;
        exRegWrite  = 1'b0;
    endtask

    task automatic setOp(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] sdata, input logic [15:0] alu,
                         input logic [2:0] rdIdx, input logic regW);
        exValid     = 1'b1;
        exMemRead   = rd;
        exMemWrite  = wr;
        exAddr      = addr;
        exStoreData = sdata;
        exAluResult = alu;
        exRd        = rdIdx;
        exRegWrite  = regW;
    endtask

    task automatic doReset();
        setIdle();
        rstN1 = 1'b0;
        rstN3 = 1'b0;
        tick();
        rstN1 = 1'b1;
        rstN3 = 1'b1;
    endtask

    task automatic test_reset();
        setOp(1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 3'd5, 1'b1);
        rstN1 = 1'b0;
        rstN3 = 1'b0;
        loadMem = 1'b1;
        tick();
        tick();
        loadMem = 1'b0;
        if (readMem1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_mem got %h exp 0", readMem1); end checks++;
        if (writeMem1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_mem got %h exp 0", writeMem1); end checks++;
        if (rwAddress1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rw_address got %h exp 0000", rwAddress1); end checks++;
        if (writeData1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_write_data got %h exp 0000", writeData1); end checks++;
        if (wbValid1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid got %h exp 0", wbValid1); end checks++;
        if (wbRegWrite1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_reg_write got %h exp 0", wbRegWrite1); end checks++;
        if (wbRd1 !== 3'd0) begin errors++; $display("[TB] FAIL reset_wb_rd got %h exp 0", wbRd1); end checks++;
        if (wbData1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wb_data got %h exp 0000", wbData1); end checks++;
        if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %h exp 0", stall1); end checks++;
        setIdle();
        rstN1 = 1'b1;
        rstN3 = 1'b1;
        #1;
        if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_stall got %h exp 0", stall1); end checks++;
        tick();
        if (readMem1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_read_mem got %h exp 0", readMem1); end checks++;
    endtask

    task automatic test_load();
        doReset();
        setOp(1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 3'd5, 1'b1);
        #1;
        if (stall1 !== 1'b1) begin errors++; $display("[TB] FAIL load_accept_stall got %h exp 1", stall1); end checks++;
        if (readMem1 !== 1'b0) begin errors++; $display("[TB] FAIL load_accept_read_mem got %h exp 0", readMem1); end checks++;
        tick();
        if (readMem1 !== 1'b1) begin errors++; $display("[TB] FAIL load_read_mem got %h exp 1", readMem1); end checks++;
        if (writeMem1 !== 1'b0) begin errors++; $display("[TB] FAIL load_write_mem got %h exp 0", writeMem1); end checks++;
        if (rwAddress1 !== 16'h0003) begin errors++; $display("[TB] FAIL load_rw_address got %h exp 0003", rwAddress1); end checks++;
        if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL load_access_stall got %h exp 0", stall1); end checks++;
        if (wbValid1 !== 1'b0) begin errors++; $display("[TB] FAIL load_early_wb_valid got %h exp 0", wbValid1); end checks++;
        tick();
        setIdle();
        if (wbValid1 !== 1'b1) begin errors++; $display("[TB] FAIL load_wb_valid got %h exp 1", wbValid1); end checks++;
        if (wbData1 !== 16'hBEEF) begin errors++; $display("[TB] FAIL load_wb_data got %h exp beef", wbData1); end checks++;
        if (wbRd1 !== 3'd5) begin errors++; $display("[TB] FAIL load_wb_rd got %h exp 5", wbRd1); end checks++;
        if (wbRegWrite1 !== 1'b1) begin errors++; $display("[TB] FAIL load_wb_reg_write got %h exp 1", wbRegWrite1); end checks++;
        if (readMem1 !== 1'b0) begin errors++; $display("[TB] FAIL load_strobe_drop got %h exp 0", readMem1); end checks++;
        tick();
        if (wbValid1 !== 1'b0) begin errors++; $display("[TB] FAIL load_wb_pulse_end got %h exp 0", wbValid1); end checks++;
    endtask

    task automatic test_store_load();
        doReset();
        setOp(1'b0, 1'b1, 16'h0007, 16'h1234, 16'h0055, 3'd2, 1'b1);
        tick();
        if (writeMem1 !== 1'b1) begin errors++; $display("[TB] FAIL store_write_mem got %h exp 1", writeMem1); end checks++;
        if (readMem1 !== 1'b0) begin errors++; $display("[TB] FAIL store_read_mem got %h exp 0", readMem1); end checks++;
        if (writeData1 !== 16'h1234) begin errors++; $display("[TB] FAIL store_write_data got %h exp 1234", writeData1); end checks++;
        if (rwAddress1 !== 16'h0007) begin errors++; $display("[TB] FAIL store_rw_address got %h exp 0007", rwAddress1); end checks++;
        setOp(1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0000, 3'd6, 1'b1);
        tick();
        if (wbValid1 !== 1'b1) begin errors++; $display("[TB] FAIL store_wb_valid got %h exp 1", wbValid1); end checks++;
        if (wbRegWrite1 !== 1'b0) begin errors++; $display("[TB] FAIL store_wb_reg_write got %h exp 0", wbRegWrite1); end checks++;
        if (wbData1 !== 16'h0055) begin errors++; $display("[TB] FAIL store_wb_data got %h exp 0055", wbData1); end checks++;
        if (writeMem1 !== 1'b0) begin errors++; $display("[TB] FAIL store_strobe_drop got %h exp 0", writeMem1); end checks++;
        if (stall1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_stall got %h exp 1", stall1); end checks++;
        tick();
        setIdle();
        if (readMem1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_read_mem got %h exp 1", readMem1); end checks++;
        if (wbValid1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wb_gap got %h exp 0", wbValid1); end checks++;
        tick();
        if (wbValid1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_load_wb_valid got %h exp 1", wbValid1); end checks++;
        if (wbData1 !== 16'h1234) begin errors++; $display("[TB] FAIL b2b_load_wb_data got %h exp 1234", wbData1); end checks++;
        if (wbRd1 !== 3'd6) begin errors++; $display("[TB] FAIL b2b_load_wb_rd got %h exp 6", wbRd1); end checks++;
    endtask

    task automatic test_both_flags();
        doReset();
        setOp(1'b1, 1'b1, 16'h0009, 16'hABCD, 16'h0011, 3'd1, 1'b1);
        tick();
        setIdle();
        if (writeMem1 !== 1'b1) begin errors++; $display("[TB] FAIL both_write_mem got %h exp 1", writeMem1); end checks++;
        if (readMem1 !== 1'b0) begin errors++; $display("[TB] FAIL both_read_mem got %h exp 0", readMem1); end checks++;
        tick();
        if (wbRegWrite1 !== 1'b0) begin errors++; $display("[TB] FAIL both_wb_reg_write got %h exp 0", wbRegWrite1); end checks++;
        if (wbData1 !== 16'h0011) begin errors++; $display("[TB] FAIL both_wb_data got %h exp 0011", wbData1); end checks++;
    endtask

    task automatic test_wait3();
        doReset();
        setOp(1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 3'd3, 1'b1);
        #1;
        if (stall3 !== 1'b1) begin errors++; $display("[TB] FAIL w3_accept_stall got %h exp 1", stall3); end checks++;
        tick();
        // Different request on ex_* during ACCESS must be ignored.
        setOp(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            if (readMem3 !== 1'b1) begin errors++; $display("[TB] FAIL w3_read_mem cycle %0d got %h exp 1", i, readMem3); end checks++;
            if (rwAddress3 !== 16'h0004) begin errors++; $display("[TB] FAIL w3_rw_address cycle %0d got %h exp 0004", i, rwAddress3); end checks++;
            if (stall3 !== (i < 2)) begin errors++; $display("[TB] FAIL w3_stall cycle %0d got %h exp %h", i, stall3, (i < 2)); end checks++;
            if (wbValid3 !== 1'b0) begin errors++; $display("[TB] FAIL w3_early_wb cycle %0d got %h exp 0", i, wbValid3); end checks++;
            if (i == 2) setIdle();
            tick();
        end
        if (wbValid3 !== 1'b1) begin errors++; $display("[TB] FAIL w3_wb_valid got %h exp 1", wbValid3); end checks++;
        if (wbData3 !== 16'hCAFE) begin errors++; $display("[TB] FAIL w3_wb_data got %h exp cafe", wbData3); end checks++;
        if (wbRd3 !== 3'd3) begin errors++; $display("[TB] FAIL w3_wb_rd got %h exp 3", wbRd3); end checks++;
        if (readMem3 !== 1'b0) begin errors++; $display("[TB] FAIL w3_strobe_drop got %h exp 0", readMem3); end checks++;
    endtask

    task automatic test_alu_stream();
        int idx;
        doReset();
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            if (idx < 6) setOp(LOAD_TAB[idx], 1'b0, 16'h0003, 16'h0000, ALU_TAB[idx], 3'd4, 1'b1);
            else setIdle();
            #1;
            if (stall1 !== EXP_STALL[c]) begin errors++; $display("[TB] FAIL stream_stall cycle %0d got %h exp %h", c, stall1, EXP_STALL[c]); end checks++;
            tick();
            if (wbValid1 !== EXP_WBV[c]) begin errors++; $display("[TB] FAIL stream_wb_valid cycle %0d got %h exp %h", c, wbValid1, EXP_WBV[c]); end checks++;
            if (EXP_WBV[c]) begin
                if (wbData1 !== EXP_WBD[c]) begin errors++; $display("[TB] FAIL stream_wb_data cycle %0d got %h exp %h", c, wbData1, EXP_WBD[c]); end checks++;
            end
            if (!EXP_STALL[c]) idx++;
        end
        setIdle();
    endtask

    task automatic test_reset_mid();
        doReset();
        setOp(1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 3'd2, 1'b1);
        tick();
        tick();
        if (readMem3 !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_read_mem got %h exp 1", readMem3); end checks++;
        setIdle();
        rstN3 = 1'b0;
        tick();
        if (readMem3 !== 1'b0) begin errors++; $display("[TB] FAIL mid_read_mem got %h exp 0", readMem3); end checks++;
        if (wbValid3 !== 1'b0) begin errors++; $display("[TB] FAIL mid_wb_valid got %h exp 0", wbValid3); end checks++;
        rstN3 = 1'b1;
        tick();
        if (wbValid3 !== 1'b0) begin errors++; $display("[TB] FAIL mid_post_wb_valid got %h exp 0", wbValid3); end checks++;
        if (stall3 !== 1'b0) begin errors++; $display("[TB] FAIL mid_post_stall got %h exp 0", stall3); end checks++;
        // An ALU op retiring next edge shows the FSM is back in IDLE.
        setOp(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00A5, 3'd1, 1'b1);
        tick();
        setIdle();
        if (wbValid3 !== 1'b1) begin errors++; $display("[TB] FAIL mid_idle_wb_valid got %h exp 1", wbValid3); end checks++;
        if (wbData3 !== 16'h00A5) begin errors++; $display("[TB] FAIL mid_idle_wb_data got %h exp 00a5", wbData3); end checks++;
    endtask

    // Scenario sequence, then the one summary line.
    initial begin
        checks  = 0;
        errors  = 0;
        loadMem = 1'b1;
        rstN1   = 1'b0;
        rstN3   = 1'b0;
        setIdle();
        $display("[TB] starting mem_access_ctrl bench");
        test_reset();
        test_load();
        test_store_load();
        test_both_flags();
        test_wait3();
        test_alu_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
